// File: rtl/tb_mem_arb_pkg.sv
// Shared types, constants and helpers for the testbench memory arbiter.
//  mem_req_t   : one master's request payload at the default widths
//  LfsrTaps    : feedback mask for the 16-bit stall LFSR (taps 16,14,13,11)
//  LfsrDefaultSeed : default nonzero LFSR seed
//  onehot2idx  : index of the set bit in a one-hot vector (up to 32 bits)
package tb_mem_arb_pkg;

  localparam int unsigned ArbAddrWidth = 32;
  localparam int unsigned ArbDataWidth = 32;
  localparam int unsigned ArbBeWidth   = ArbDataWidth / 8;

  typedef struct packed {
    logic [ArbAddrWidth-1:0] addr;
    logic                    we;
    logic [ArbBeWidth-1:0]   be;
    logic [ArbDataWidth-1:0] wdata;
  } mem_req_t;

  // Bits 15,13,12,10 of the shift register, i.e. taps 16,14,13,11.
  localparam logic [15:0] LfsrTaps        = 16'hB400;
  localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;

  function automatic int unsigned onehot2idx(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tb_rr_arbiter.sv
// Round-robin arbiter holding the priority pointer.
//  clk, rst : clock, synchronous active-high reset
//  req      : per-requester request vector
//  stall    : suppress all grants this cycle (pointer holds)
//  gnt      : one-hot grant, combinational
//  idx      : binary index of the granted requester (valid when |gnt)
module tb_rr_arbiter
  import tb_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       stall,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IdxWidth = $clog2(NUM_REQ);

  logic [IdxWidth-1:0] prio_q;
  logic                found;
  int unsigned         pos;

  // Scan requesters in cyclic order starting at the pointer; first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = (32'(prio_q) + unsigned'(i)) % NUM_REQ;
      if (!found && !stall && req[pos[IdxWidth-1:0]]) begin
        gnt[pos[IdxWidth-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
  end

  assign idx = IdxWidth'(onehot2idx(32'(gnt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= '0;
    end else if (|gnt) begin
      prio_q <= (idx == IdxWidth'(NUM_REQ - 1)) ? '0 : idx + IdxWidth'(1);
    end
  end

endmodule

// File: rtl/tb_mem_arbiter.sv
// Shares one single-port, 1-cycle-latency testbench RAM between NUM_MASTERS OBI-style
// requesters: round-robin grant, response routing and a saturating contention counter.
//  clk_i, rst_i     : clock, synchronous active-high reset
//  m_req_i .. m_wdata_i : packed per-master request bundles
//  m_gnt_o          : one-hot grant (combinational)
//  m_rvalid_o       : one-hot response valid, one cycle after the grant
//  m_rdata_o        : broadcast read data, valid with m_rvalid_o
//  mem_*_o          : RAM request, muxed from the granted master ('0 when idle)
//  mem_rdata_i      : RAM read data, one cycle after mem_req_o
//  conflict_cnt_o   : cycles with two or more requesters, saturating
// Optional feature: define TB_ARB_STALL_INJECT_EN to add LFSR-driven random grant stalls.
module tb_mem_arbiter
  import tb_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter logic [15:0] STALL_SEED  = LfsrDefaultSeed
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_MASTERS-1:0]                 m_req_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_addr_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]  m_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
  output logic [NUM_MASTERS-1:0]                 m_gnt_o,
  output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  m_rdata_o,
  output logic                                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
  output logic                                   mem_we_o,
  output logic [DATA_WIDTH/8-1:0]                mem_be_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
  output logic [CNT_WIDTH-1:0]                   conflict_cnt_o
);

  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned IdxWidth = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] gnt;
  logic [IdxWidth-1:0]    gnt_idx;
  logic                   lfsr_stall;
  logic                   arb_stall;
  logic                   rvalid_q;
  logic [IdxWidth-1:0]    owner_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   conflict;
  int unsigned            n_req;

`ifdef TB_ARB_STALL_INJECT_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  assign lfsr_stall = (lfsr_q[1:0] == 2'b00);
`else
  assign lfsr_stall = 1'b0;

  // The seed only matters with stall injection; nothing is built here.
  if (STALL_SEED == 16'h0) begin : g_seed_unused
  end
`endif

  // Reset also blocks grants so no RAM access starts while in reset.
  assign arb_stall = rst_i | lfsr_stall;

  tb_rr_arbiter #(
    .NUM_REQ (NUM_MASTERS)
  ) u_rr_arbiter (
    .clk   (clk_i),
    .rst   (rst_i),
    .req   (m_req_i),
    .stall (arb_stall),
    .gnt   (gnt),
    .idx   (gnt_idx)
  );

  assign m_gnt_o   = gnt;
  assign mem_req_o = |gnt;

  // Grant is one-hot, so at most one branch fires; idle leaves everything at '0.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt[k]) begin
        mem_addr_o  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        mem_we_o    = m_we_i[k];
        mem_be_o    = m_be_i[k*BeWidth +: BeWidth];
        mem_wdata_o = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Response tracking: remember who was granted; the RAM answers one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      rvalid_q <= |gnt;
      owner_q  <= gnt_idx;
    end
  end

  always_comb begin
    m_rvalid_o = '0;
    if (rvalid_q) m_rvalid_o[owner_q] = 1'b1;
  end

  assign m_rdata_o = mem_rdata_i;

  // Contention is measured on requests, independent of stalls.
  always_comb begin
    n_req = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      n_req = n_req + 32'(m_req_i[k]);
    end
  end

  assign conflict = (n_req >= 2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (conflict && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Self-checking bench for tb_mem_arbiter (2 masters). A queue-free behavioural model computes
// grant/mux/response/counter expectations every cycle; directed steps add literal checks.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_tb_mem_arbiter;
  import tb_mem_arb_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  mem_req_t        mst [N];
  logic [N-1:0]    req;
  logic [N*AW-1:0] m_addr;
  logic [N-1:0]    m_we;
  logic [N*BW-1:0] m_be;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   mem_rdata;

  logic [N-1:0]  gnt, rvalid, gnt_s, rvalid_s;
  logic [DW-1:0] rdata, rdata_s;
  logic          mem_req, mem_we, mem_req_s, mem_we_s;
  logic [AW-1:0] mem_addr, mem_addr_s;
  logic [BW-1:0] mem_be, mem_be_s;
  logic [DW-1:0] mem_wdata, mem_wdata_s;
  logic [31:0]   cnt;
  logic [3:0]    cnt4;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = mst[i].addr;
      m_we[i]             = mst[i].we;
      m_be[i*BW +: BW]    = mst[i].be;
      m_wdata[i*DW +: DW] = mst[i].wdata;
    end
  end

  tb_mem_arbiter #(
    .NUM_MASTERS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .CNT_WIDTH (32),
    .STALL_SEED  (16'hACE1)
  ) dut (
    .clk_i (clk), .rst_i (rst), .m_req_i (req), .m_addr_i (m_addr), .m_we_i (m_we),
    .m_be_i (m_be), .m_wdata_i (m_wdata), .m_gnt_o (gnt), .m_rvalid_o (rvalid),
    .m_rdata_o (rdata), .mem_req_o (mem_req), .mem_addr_o (mem_addr), .mem_we_o (mem_we),
    .mem_be_o (mem_be), .mem_wdata_o (mem_wdata), .mem_rdata_i (mem_rdata),
    .conflict_cnt_o (cnt)
  );

  tb_mem_arbiter #(
    .NUM_MASTERS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .CNT_WIDTH (4),
    .STALL_SEED  (16'hACE1)
  ) dut_sat (
    .clk_i (clk), .rst_i (rst), .m_req_i (req), .m_addr_i (m_addr), .m_we_i (m_we),
    .m_be_i (m_be), .m_wdata_i (m_wdata), .m_gnt_o (gnt_s), .m_rvalid_o (rvalid_s),
    .m_rdata_o (rdata_s), .mem_req_o (mem_req_s), .mem_addr_o (mem_addr_s),
    .mem_we_o (mem_we_s), .mem_be_o (mem_be_s), .mem_wdata_o (mem_wdata_s),
    .mem_rdata_i (mem_rdata), .conflict_cnt_o (cnt4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pointer, pending response, counters, stall LFSR.
  int          exp_prio;
  bit          exp_pend;
  int          exp_owner;
  longint      exp_cnt;
  int          exp_cnt4;
  logic [15:0] exp_lfsr;

  bit stat_en;
  int g_cnt [N];
  int rv_cnt [N];
  int stall_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_prio  = 0;
    exp_pend  = 1'b0;
    exp_owner = 0;
    exp_cnt   = 0;
    exp_cnt4  = 0;
    exp_lfsr  = 16'hACE1;
  endtask

  // Checks every DUT output for the current cycle, then advances the model past the edge.
  task automatic model_cycle();
    logic [N-1:0]  e_gnt, e_rv;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wdata;
    int            k, c, pop;
    bit            stall;
    e_gnt = '0;
    e_rv  = '0;
    k     = -1;
    stall = 1'b0;
`ifdef TB_ARB_STALL_INJECT_EN
    stall = (exp_lfsr[1:0] == 2'b00);
`endif
    if (!rst && !stall) begin
      for (int i = 0; i < N; i++) begin
        c = (exp_prio + i) % N;
        if (k < 0 && req[c]) k = c;
      end
    end
    e_addr = '0; e_we = 1'b0; e_be = '0; e_wdata = '0;
    if (k >= 0) begin
      e_gnt[k] = 1'b1;
      e_addr   = mst[k].addr;
      e_we     = mst[k].we;
      e_be     = mst[k].be;
      e_wdata  = mst[k].wdata;
    end
    if (exp_pend) e_rv[exp_owner] = 1'b1;

    check("gnt", 64'(gnt), 64'(e_gnt));
    check("mem_req", 64'(mem_req), 64'(k >= 0));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_be", 64'(mem_be), 64'(e_be));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    check("rvalid", 64'(rvalid), 64'(e_rv));
    if (exp_pend) check("rdata", 64'(rdata), 64'(mem_rdata));
    check("cnt", 64'(cnt), 64'(exp_cnt));
    check("gnt_sat", 64'(gnt_s), 64'(e_gnt));
    check("cnt_sat", 64'(cnt4), 64'(exp_cnt4));

    if (stat_en) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) g_cnt[i]++;
        if (rvalid[i]) rv_cnt[i]++;
      end
      if (stall && !rst) stall_seen++;
    end

    pop = $countones(req);
    if (rst) begin
      model_reset();
    end else begin
      exp_pend  = (k >= 0);
      exp_owner = (k >= 0) ? k : 0;
      if (k >= 0) exp_prio = (k + 1) % N;
      if (pop >= 2) begin
        if (exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
        if (exp_cnt4 < 15) exp_cnt4++;
      end
      exp_lfsr = {exp_lfsr[14:0], exp_lfsr[15] ^ exp_lfsr[13] ^ exp_lfsr[12] ^ exp_lfsr[10]};
    end
  endtask

  task automatic sample_cycle();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req = '0;
    for (int i = 0; i < N; i++) mst[i] = '0;
  endtask

  task automatic set_m(input int i, input logic [AW-1:0] addr, input logic we,
                       input logic [BW-1:0] be, input logic [DW-1:0] wdata);
    req[i]       = 1'b1;
    mst[i].addr  = addr;
    mst[i].we    = we;
    mst[i].be    = be;
    mst[i].wdata = wdata;
  endtask

  // Directed vectors checked only against the model: {req, we0, we1}.
  logic [3:0] vec [6] = '{4'b10_00, 4'b00_00, 4'b11_10, 4'b01_00, 4'b11_01, 4'b10_01};

  initial begin
    logic [3:0] v;
    rst       = 1'b1;
    mem_rdata = '0;
    stat_en   = 1'b0;
    stall_seen = 0;
    for (int i = 0; i < N; i++) begin g_cnt[i] = 0; rv_cnt[i] = 0; end
    idle_all();
    model_reset();
    next_cycle();

    // Reset state
    sample_cycle();
    check("reset_gnt", 64'(gnt), 64'h0);
    check("reset_mem_req", 64'(mem_req), 64'h0);
    check("reset_rvalid", 64'(rvalid), 64'h0);
    check("reset_cnt", 64'(cnt), 64'h0);
    next_cycle();
    sample_cycle();
    next_cycle();

`ifndef TB_ARB_STALL_INJECT_EN
    // Single read by master 0
    rst = 1'b0;
    set_m(0, 32'h80, 1'b0, 4'hF, 32'h0);
    sample_cycle();
    check("t1_gnt", 64'(gnt), 64'h1);
    check("t1_addr", 64'(mem_addr), 64'h80);
    next_cycle();
    idle_all();
    mem_rdata = 32'hDEAD_BEEF;
    sample_cycle();
    check("t1_rvalid", 64'(rvalid), 64'h1);
    check("t1_rdata", 64'(rdata), 64'hDEAD_BEEF);
    next_cycle();

    // Fresh reset, then four cycles of full contention
    rst = 1'b1;
    sample_cycle();
    next_cycle();
    rst = 1'b0;
    set_m(0, 32'h100, 1'b0, 4'hF, 32'h0);
    set_m(1, 32'h200, 1'b0, 4'hF, 32'h0);
    for (int c = 0; c < 4; c++) begin
      mem_rdata = 32'h1111_0000 + 32'(c);
      sample_cycle();
      check("t2_gnt", 64'(gnt), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c > 0) check("t2_rvalid", 64'(rvalid), (c % 2 == 1) ? 64'h1 : 64'h2);
      next_cycle();
    end
    idle_all();
    sample_cycle();
    check("t2_rvalid_last", 64'(rvalid), 64'h2);
    check("t2_cnt", 64'(cnt), 64'd4);
    next_cycle();

    // Master 1 write
    set_m(1, 32'h1000, 1'b1, 4'b0011, 32'h1234);
    sample_cycle();
    check("t3_gnt", 64'(gnt), 64'h2);
    check("t3_we", 64'(mem_we), 64'h1);
    check("t3_be", 64'(mem_be), 64'h3);
    check("t3_wdata", 64'(mem_wdata), 64'h1234);
    check("t3_addr", 64'(mem_addr), 64'h1000);
    next_cycle();
    idle_all();
    sample_cycle();
    check("t3_rvalid", 64'(rvalid), 64'h2);
    next_cycle();

    // Reset lands on the edge that would register the response
    set_m(0, 32'h300, 1'b0, 4'hF, 32'h0);
    sample_cycle();
    check("t4_gnt", 64'(gnt), 64'h1);
    #1;
    rst = 1'b1;
    idle_all();
    model_reset();
    next_cycle();
    sample_cycle();
    check("t4_rvalid_dropped", 64'(rvalid), 64'h0);
    check("t4_gnt_in_reset", 64'(gnt), 64'h0);
    next_cycle();
    rst = 1'b0;
    set_m(0, 32'h400, 1'b0, 4'hF, 32'h0);
    set_m(1, 32'h500, 1'b1, 4'hC, 32'h55AA);
    sample_cycle();
    check("t4_gnt_after_reset", 64'(gnt), 64'h1);
    next_cycle();

    // Saturation of the narrow counter
    for (int c = 0; c < 20; c++) begin
      sample_cycle();
      next_cycle();
    end
    idle_all();
    sample_cycle();
    check("t5_cnt4_sat", 64'(cnt4), 64'hF);
    check("t5_cnt", 64'(cnt), 64'd21);
    next_cycle();
`endif

    // Mixed directed vectors
    rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      v = vec[r];
      idle_all();
      if (v[2]) set_m(0, 32'h600 + 32'(r), v[1], 4'h5, 32'hA000 + 32'(r));
      if (v[3]) set_m(1, 32'h700 + 32'(r), v[0], 4'hA, 32'hB000 + 32'(r));
      mem_rdata = 32'hC0DE_0000 + 32'(r);
      sample_cycle();
      next_cycle();
    end
    idle_all();
    sample_cycle();
    next_cycle();

`ifdef TB_ARB_STALL_INJECT_EN
    // Random back-pressure under full contention
    rst = 1'b1;
    sample_cycle();
    next_cycle();
    rst = 1'b0;
    stat_en = 1'b1;
    set_m(0, 32'h800, 1'b0, 4'hF, 32'h0);
    set_m(1, 32'h900, 1'b0, 4'hF, 32'h0);
    for (int c = 0; c < 1000; c++) begin
      mem_rdata = 32'(c);
      sample_cycle();
      next_cycle();
    end
    idle_all();
    sample_cycle();
    next_cycle();
    stat_en = 1'b0;
    for (int i = 0; i < N; i++) check("t6_one_rvalid_per_gnt", 64'(rv_cnt[i]), 64'(g_cnt[i]));
    check("t6_fair", 64'((g_cnt[0] - g_cnt[1] <= 1) && (g_cnt[1] - g_cnt[0] <= 1)), 64'h1);
    check("t6_some_stalls", 64'(stall_seen > 0), 64'h1);
    check("t6_total_grants", 64'(g_cnt[0] + g_cnt[1]), 64'(1000 - stall_seen));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
